// File: rtl/pong_score_ctrl.sv
// pong_score_ctrl: two-player BCD score keeper and game-flow FSM (NEWGAME/PLAY/NEWBALL/OVER)
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   p1_point, p2_point  one-cycle point pulses from the physics block
//   btn_start           debounced, synchronized start button level
//   dig0..dig3          BCD digits: p1 ones, p1 tens, p2 ones, p2 tens
//   rule_en, over_en    text overlay enables (rules in NEWGAME, game over in OVER)
//   ball_hold, serve    ball held outside PLAY; serve pulses on each PLAY entry
//   winner              00 none, 01 player 1, 10 player 2, 11 draw
// Macro PONG_AUTO_SERVE_EN: when defined NEWBALL serves automatically after the
// delay; when undefined it waits for a start button rising edge after the delay.
module pong_score_ctrl #(
    parameter int WIN_SCORE    = 11,
    parameter int DELAY_CYCLES = 200000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1_point,
    input  logic       p2_point,
    input  logic       btn_start,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       rule_en,
    output logic       over_en,
    output logic       ball_hold,
    output logic       serve,
    output logic [1:0] winner
);
    localparam int CW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DELAY_CYCLES - 1);
    localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    typedef enum logic [1:0] {NEWGAME, PLAY, NEWBALL, OVER} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_btn_q;
    logic          w_start_rise;
    logic          w_expired;
    logic          w_serve_ok;
    logic          w_any_point;
    logic          w_p1_win;
    logic          w_p2_win;
    logic [7:0]    w_p1_next;
    logic [7:0]    w_p2_next;

    // Two-digit BCD increment, saturating at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v == 8'h99) ? v :
               (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_start_rise = btn_start & ~r_btn_q;
    assign w_expired    = (r_cnt == LAST);
    assign w_any_point  = p1_point | p2_point;
    assign w_p1_next    = p1_point ? bcd_inc({dig1, dig0}) : {dig1, dig0};
    assign w_p2_next    = p2_point ? bcd_inc({dig3, dig2}) : {dig3, dig2};
    assign w_p1_win     = p1_point && (w_p1_next == WIN_BCD);
    assign w_p2_win     = p2_point && (w_p2_next == WIN_BCD);

`ifdef PONG_AUTO_SERVE_EN
    assign w_serve_ok = w_expired;
`else
    // Manual serve: only a rising edge seen after the delay has run out counts.
    assign w_serve_ok = w_expired & w_start_rise;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= NEWGAME;
            r_cnt     <= '0;
            r_btn_q   <= 1'b0;
            dig0      <= 4'd0;
            dig1      <= 4'd0;
            dig2      <= 4'd0;
            dig3      <= 4'd0;
            winner    <= 2'b00;
            serve     <= 1'b0;
            over_en   <= 1'b0;
            rule_en   <= 1'b1;
            ball_hold <= 1'b1;
        end else begin
            r_btn_q <= btn_start;
            serve   <= 1'b0;
            case (r_state)
                NEWGAME: if (w_start_rise) begin
                    {dig1, dig0, dig3, dig2} <= '0;
                    winner    <= 2'b00;
                    serve     <= 1'b1;
                    rule_en   <= 1'b0;
                    ball_hold <= 1'b0;
                    r_state   <= PLAY;
                end
                PLAY: if (w_any_point) begin
                    {dig1, dig0} <= w_p1_next;
                    {dig3, dig2} <= w_p2_next;
                    ball_hold    <= 1'b1;
                    r_cnt        <= '0;
                    if (w_p1_win | w_p2_win) begin
                        // Bit 0 marks player 1, bit 1 player 2; both set is a draw.
                        winner  <= {w_p2_win, w_p1_win};
                        over_en <= 1'b1;
                        r_state <= OVER;
                    end else begin
                        r_state <= NEWBALL;
                    end
                end
                NEWBALL: if (!w_expired) begin
                    r_cnt <= r_cnt + 1'b1;
                end else if (w_serve_ok) begin
                    serve     <= 1'b1;
                    ball_hold <= 1'b0;
                    r_state   <= PLAY;
                end
                OVER: if (!w_expired) begin
                    r_cnt <= r_cnt + 1'b1;
                end else begin
                    over_en <= 1'b0;
                    rule_en <= 1'b1;
                    r_state <= NEWGAME;
                end
                default: r_state <= NEWGAME;
            endcase
        end
    end
endmodule

// File: tb/tb_pong_score_ctrl.sv
// tb_pong_score_ctrl: directed self-checking bench for pong_score_ctrl (WIN_SCORE 3 and 11, DELAY_CYCLES 8)
module tb_pong_score_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       p1 [2];
    logic       p2 [2];
    logic       btn [2];
    logic [3:0] dig0 [2];
    logic [3:0] dig1 [2];
    logic [3:0] dig2 [2];
    logic [3:0] dig3 [2];
    logic       rule_en [2];
    logic       over_en [2];
    logic       ball_hold [2];
    logic       serve [2];
    logic [1:0] winner [2];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    pong_score_ctrl #(.WIN_SCORE(3), .DELAY_CYCLES(8)) u_a (
        .clk(clk), .reset(reset), .p1_point(p1[0]), .p2_point(p2[0]), .btn_start(btn[0]),
        .dig0(dig0[0]), .dig1(dig1[0]), .dig2(dig2[0]), .dig3(dig3[0]),
        .rule_en(rule_en[0]), .over_en(over_en[0]), .ball_hold(ball_hold[0]),
        .serve(serve[0]), .winner(winner[0])
    );

    pong_score_ctrl #(.WIN_SCORE(11), .DELAY_CYCLES(8)) u_b (
        .clk(clk), .reset(reset), .p1_point(p1[1]), .p2_point(p2[1]), .btn_start(btn[1]),
        .dig0(dig0[1]), .dig1(dig1[1]), .dig2(dig2[1]), .dig3(dig3[1]),
        .rule_en(rule_en[1]), .over_en(over_en[1]), .ball_hold(ball_hold[1]),
        .serve(serve[1]), .winner(winner[1])
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic score(input int s, input logic a, input logic b);
        p1[s] = a;
        p2[s] = b;
        step();
        p1[s] = 1'b0;
        p2[s] = 1'b0;
    endtask

    // Wait out NEWBALL (entered by the preceding score call) and check the serve.
    task automatic resume(input int s);
`ifdef PONG_AUTO_SERVE_EN
        cyc(7);
        chk("nb_no_early_serve", {7'd0, serve[s]}, 8'd0);
        step();
`else
        cyc(10);
        chk("nb_hold_past_delay", {7'd0, ball_hold[s]}, 8'd1);
        btn[s] = 1'b1;
        step();
        btn[s] = 1'b0;
`endif
        chk("nb_serve", {7'd0, serve[s]}, 8'd1);
        chk("nb_play_ball_free", {7'd0, ball_hold[s]}, 8'd0);
    endtask

    initial begin
        int ns;
        p1  = '{1'b0, 1'b0};
        p2  = '{1'b0, 1'b0};
        btn = '{1'b0, 1'b0};
        cyc(2);
        chk("rst_digits", {dig1[0], dig0[0]} | {dig3[0], dig2[0]}, 8'h00);
        chk("rst_rule_en", {7'd0, rule_en[0]}, 8'd1);
        chk("rst_ball_hold", {7'd0, ball_hold[0]}, 8'd1);
        chk("rst_serve", {7'd0, serve[0]}, 8'd0);
        chk("rst_over_en", {7'd0, over_en[0]}, 8'd0);
        chk("rst_winner", {6'd0, winner[0]}, 8'd0);
        reset = 1'b0;
        step();
        chk("idle_rule_en", {7'd0, rule_en[0]}, 8'd1);

        // Start held for 5 cycles: exactly one serve.
        btn[0] = 1'b1;
        step();
        chk("t1_serve", {7'd0, serve[0]}, 8'd1);
        chk("t1_rule_en", {7'd0, rule_en[0]}, 8'd0);
        chk("t1_ball_hold", {7'd0, ball_hold[0]}, 8'd0);
        chk("t1_digits", {dig1[0], dig0[0]} | {dig3[0], dig2[0]}, 8'h00);
        ns = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            ns += int'(serve[0]);
        end
        chk("t1_no_retrigger", 8'(ns), 8'd0);
        btn[0] = 1'b0;
        step();

        // Player 1 point, then NEWBALL with a dropped p2 pulse.
        score(0, 1'b1, 1'b0);
        chk("t2_dig0", {4'd0, dig0[0]}, 8'd1);
        chk("t2_ball_hold", {7'd0, ball_hold[0]}, 8'd1);
        step();
        step();
        p2[0] = 1'b1;
        step();
        p2[0] = 1'b0;
        chk("t5_nb_p2_dropped", {4'd0, dig2[0]}, 8'd0);
        chk("t5_nb_no_serve", {7'd0, serve[0]}, 8'd0);
`ifdef PONG_AUTO_SERVE_EN
        cyc(4);
        chk("t2_serve_not_at_7", {7'd0, serve[0]}, 8'd0);
        step();
`else
        cyc(7);
        chk("t6_hold_past_delay", {7'd0, serve[0]}, 8'd0);
        chk("t6_still_held", {7'd0, ball_hold[0]}, 8'd1);
        btn[0] = 1'b1;
        step();
        btn[0] = 1'b0;
`endif
        chk("t2_serve_at_8", {7'd0, serve[0]}, 8'd1);

        // Bring scores to 2:2.
        score(0, 1'b1, 1'b0);
        chk("p1_two", {dig1[0], dig0[0]}, 8'h02);
        resume(0);
        score(0, 1'b0, 1'b1);
        chk("p2_one", {dig3[0], dig2[0]}, 8'h01);
        resume(0);
        score(0, 1'b0, 1'b1);
        chk("p2_two", {dig3[0], dig2[0]}, 8'h02);
        resume(0);

        // Simultaneous winning points: draw.
        score(0, 1'b1, 1'b1);
        chk("t3_p1", {dig1[0], dig0[0]}, 8'h03);
        chk("t3_p2", {dig3[0], dig2[0]}, 8'h03);
        chk("t3_winner", {6'd0, winner[0]}, 8'd3);
        chk("t3_over_en", {7'd0, over_en[0]}, 8'd1);
        chk("t3_ball_hold", {7'd0, ball_hold[0]}, 8'd1);
        step();
        btn[0] = 1'b1;
        p1[0]  = 1'b1;
        step();
        btn[0] = 1'b0;
        p1[0]  = 1'b0;
        cyc(5);
        chk("t5_over_held_7", {7'd0, over_en[0]}, 8'd1);
        chk("t5_over_start_ignored", {7'd0, rule_en[0]}, 8'd0);
        chk("t5_over_point_dropped", {dig1[0], dig0[0]}, 8'h03);
        step();
        chk("t3_over_done", {7'd0, over_en[0]}, 8'd0);
        chk("t3_rule_en", {7'd0, rule_en[0]}, 8'd1);
        chk("t3_keep_p1", {dig1[0], dig0[0]}, 8'h03);
        chk("t3_keep_p2", {dig3[0], dig2[0]}, 8'h03);
        chk("t3_keep_winner", {6'd0, winner[0]}, 8'd3);

        // New game clears the board.
        btn[0] = 1'b1;
        step();
        btn[0] = 1'b0;
        chk("ng_serve", {7'd0, serve[0]}, 8'd1);
        chk("ng_clear", {dig1[0], dig0[0]} | {dig3[0], dig2[0]}, 8'h00);
        chk("ng_winner", {6'd0, winner[0]}, 8'd0);

        // Asynchronous reset partway through NEWBALL.
        score(0, 1'b1, 1'b0);
        chk("t6_dig0", {4'd0, dig0[0]}, 8'd1);
        cyc(3);
        reset = 1'b1;
        #1;
        chk("t6_async_dig0", {4'd0, dig0[0]}, 8'd0);
        chk("t6_async_rule_en", {7'd0, rule_en[0]}, 8'd1);
        chk("t6_async_ball_hold", {7'd0, ball_hold[0]}, 8'd1);
        chk("t6_async_over_en", {7'd0, over_en[0]}, 8'd0);
        step();
        reset = 1'b0;
        cyc(10);
        chk("t6_stays_newgame", {7'd0, rule_en[0]}, 8'd1);
        chk("t6_no_serve", {7'd0, serve[0]}, 8'd0);

        // WIN_SCORE 11: carry at ten, win on eleventh.
        btn[1] = 1'b1;
        step();
        btn[1] = 1'b0;
        chk("t4_serve", {7'd0, serve[1]}, 8'd1);
        for (int i = 0; i < 10; i++) begin
            score(1, 1'b1, 1'b0);
            resume(1);
        end
        chk("t4_ten", {dig1[1], dig0[1]}, 8'h10);
        chk("t4_no_winner", {6'd0, winner[1]}, 8'd0);
        score(1, 1'b1, 1'b0);
        chk("t4_eleven", {dig1[1], dig0[1]}, 8'h11);
        chk("t4_winner", {6'd0, winner[1]}, 8'd1);
        chk("t4_over_en", {7'd0, over_en[1]}, 8'd1);
        chk("t4_p2_zero", {dig3[1], dig2[1]}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
